serial_adder_ctrl: RTL and testbench
====================================

SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits, legal range 1..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start_valid, input, 1 bit: requester presents operands.
REQ-005 SHALL have port start_ready, output, 1 bit: the controller can accept operands.
REQ-006 SHALL have port a, input, WIDTH bits: operand A, sampled at accept.
REQ-007 SHALL have port b, input, WIDTH bits: operand B, sampled at accept.
REQ-008 SHALL have port cin, input, 1 bit: carry-in, sampled at accept.
REQ-009 SHALL have port sum, output, WIDTH bits: result.
REQ-010 SHALL have port cout, output, 1 bit: final carry-out.
REQ-011 SHALL have port done_valid, output, 1 bit: sum and cout are valid.
REQ-012 SHALL have port done_ready, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have port busy, output, 1 bit: high in SHIFT.

Function
REQ-014 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-015 SHALL drive start_ready high only in IDLE.
REQ-016 SHALL drive done_valid high only in DONE.
REQ-017 SHALL treat an accept as a rising edge in IDLE with start_valid=1; it loads a, b and cin into shift/carry registers, clears the bit counter and moves to SHIFT.
REQ-018 SHALL process one bit per SHIFT edge, LSB first: sum bit = a0^b0^carry; carry updates; the result register shifts right, inserting the new bit at the MSB.
REQ-019 SHALL, on the edge that processes bit WIDTH-1, move to DONE, load cout with the final carry and hold the counter at WIDTH-1 maximum, so the counter never wraps past it.
REQ-020 SHALL assert done_valid exactly WIDTH rising edges after the accept edge, giving a latency of WIDTH cycles; WIDTH=1 gives done_valid on the next cycle.
REQ-021 SHALL hold sum and cout stable in DONE until an edge with done_ready=1, which moves the FSM to IDLE.
REQ-022 SHALL not allow an accept on the same edge as that DONE-to-IDLE transition; the next accept occurs one cycle later at the earliest.
REQ-023 SHALL ignore start_valid, a, b and cin in SHIFT and DONE, and ignore done_ready outside DONE.
REQ-024 SHALL produce sum = (a+b+cin) mod 2^WIDTH and cout = bit WIDTH of (a+b+cin).
REQ-025 SHALL NOT reach an illegal FSM encoding; any such encoding returns the FSM to IDLE on the next edge.

Reset
REQ-026 SHALL, when rst is asserted, immediately force state=IDLE, start_ready=1, done_valid=0, busy=0, sum=0, cout=0, and clear the counter and carry, independent of clk.
REQ-027 SHALL, on reset during SHIFT or DONE, abort the operation and discard its result; the first accept is possible on the first clk edge after rst deasserts.

Structure
REQ-028 SHALL take the FSM state encodings (IDLE=0, SHIFT=1, DONE=2, 2 bits) and the counter-width function clog2(WIDTH) from a shared package serial_adder_pkg.
REQ-029 SHALL perform the per-bit add in one sub-module full_adder, built from two half_adder instances plus an OR of their carries.
REQ-030 SHALL contain no other arithmetic and no WIDTH-wide adder.

Verification
REQ-031 SHALL cover: WIDTH=8, a=3, b=5, cin=0 -> done_valid 8 cycles after accept, sum=8, cout=0.
REQ-032 SHALL cover: a=255, b=1, cin=0 -> sum=0, cout=1; and a=255, b=255, cin=1 -> sum=255, cout=1.
REQ-033 SHALL cover: done_ready held low 5 cycles -> sum/cout stable and start_ready=0 throughout; done_ready=1 -> IDLE, next accept one cycle later.
REQ-034 SHALL cover: start_valid held high and a/b changed during SHIFT -> result reflects only the operands sampled at accept.
REQ-035 SHALL cover: rst pulsed at SHIFT bit 3 -> outputs zero immediately, start_ready=1; a new add of 10+20 -> sum=30.
REQ-036 SHALL cover: WIDTH=1, a=1, b=1, cin=1 -> done_valid one cycle after accept, sum=1, cout=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared FSM encoding and sizing helper for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
    end
    return (r == 0) ? 32'd1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Single-bit adder datapath: a full adder composed of two half adders.

// Half adder: sum and carry of two bits.
module half_adder (
  input  logic i_x,
  input  logic i_y,
  output logic o_sum_c,
  output logic o_carry_c
);
  assign o_sum_c   = i_x ^ i_y;
  assign o_carry_c = i_x & i_y;
endmodule

// Full adder: chains two half adders and ORs their carries.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum_c,
  output logic o_carry_c
);
  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (
    .i_x       (i_a),
    .i_y       (i_b),
    .o_sum_c   (w_s1),
    .o_carry_c (w_c1)
  );

  half_adder u_ha1 (
    .i_x       (w_s1),
    .i_y       (i_cin),
    .o_sum_c   (o_sum_c),
    .o_carry_c (w_c2)
  );

  assign o_carry_c = w_c1 | w_c2;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: accepts operands, adds one bit per cycle LSB
// first, and presents the result until the consumer takes it.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int unsigned     CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_start_ready;
  logic             r_done_valid;
  logic             r_busy;

  logic             w_sum_bit;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_sum_shift;

  // Per-bit add of the current operand LSBs with the running carry.
  full_adder u_fa (
    .i_a       (r_a[0]),
    .i_b       (r_b[0]),
    .i_cin     (r_carry),
    .o_sum_c   (w_sum_bit),
    .o_carry_c (w_carry_nxt)
  );

  // Result register shifts right, new bit enters at the MSB.
  if (WIDTH == 1) begin : g_w1
    assign w_sum_shift = w_sum_bit;
  end else begin : g_wn
    assign w_sum_shift = {w_sum_bit, r_sum[WIDTH-1:1]};
  end

  // Controller FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_a           <= '0;
      r_b           <= '0;
      r_sum         <= '0;
      r_carry       <= 1'b0;
      r_cout        <= 1'b0;
      r_cnt         <= '0;
      r_start_ready <= 1'b1;
      r_done_valid  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_valid) begin
            r_state       <= ST_SHIFT;
            r_a           <= a;
            r_b           <= b;
            r_carry       <= cin;
            r_sum         <= '0;
            r_cout        <= 1'b0;
            r_cnt         <= '0;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_carry_nxt;
          r_sum   <= w_sum_shift;
          if (r_cnt == CNT_LAST) begin
            // Last bit: counter saturates here, never wraps.
            r_state      <= ST_DONE;
            r_cout       <= w_carry_nxt;
            r_busy       <= 1'b0;
            r_done_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // Return to IDLE only; an accept can happen no earlier than next edge.
          if (done_ready) begin
            r_state       <= ST_IDLE;
            r_done_valid  <= 1'b0;
            r_start_ready <= 1'b1;
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_start_ready <= 1'b1;
          r_done_valid  <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign done_valid  = r_done_valid;
  assign busy        = r_busy;
  assign sum         = r_sum;
  assign cout        = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  logic       clk;
  logic       rst;

  // WIDTH=8 instance signals
  logic       start_valid;
  logic       start_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic       done_valid;
  logic       done_ready;
  logic       busy;

  // WIDTH=1 instance signals
  logic       s1_start_valid;
  logic       s1_start_ready;
  logic [0:0] s1_a;
  logic [0:0] s1_b;
  logic       s1_cin;
  logic [0:0] s1_sum;
  logic       s1_cout;
  logic       s1_done_valid;
  logic       s1_done_ready;
  logic       s1_busy;

  int n_vec;
  int n_mis;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .sum         (sum),
    .cout        (cout),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .start_valid (s1_start_valid),
    .start_ready (s1_start_ready),
    .a           (s1_a),
    .b           (s1_b),
    .cin         (s1_cin),
    .sum         (s1_sum),
    .cout        (s1_cout),
    .done_valid  (s1_done_valid),
    .done_ready  (s1_done_ready),
    .busy        (s1_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One WIDTH=8 transaction, checked against plain integer addition.
  task automatic do_add8(input logic [7:0] a_i, input logic [7:0] b_i, input logic c_i,
                         input int hold, input bit perturb);
    logic [8:0] exp;
    int         lat;
    exp = 9'(a_i) + 9'(b_i) + 9'(c_i);
    a = a_i; b = b_i; cin = c_i; start_valid = 1'b1; done_ready = 1'b0;
    chk("ready_before_accept", 32'(start_ready), 32'd1);
    @(posedge clk); #1;
    start_valid = perturb;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_low_in_shift", 32'(start_ready), 32'd0);
    lat = 0;
    while (!done_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (perturb) begin
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        done_ready = 1'($urandom);
      end
    end
    done_ready = 1'b0;
    chk("latency8", 32'(lat), 32'd8);
    chk("sum8", 32'(sum), 32'(exp[7:0]));
    chk("cout8", 32'(cout), 32'(exp[8]));
    // Requester pressure while the result waits must not start a new add.
    start_valid = 1'($urandom);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_sum", 32'(sum), 32'(exp[7:0]));
      chk("hold_cout", 32'(cout), 32'(exp[8]));
      chk("hold_valid", 32'(done_valid), 32'd1);
      chk("hold_ready_low", 32'(start_ready), 32'd0);
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk("release_valid", 32'(done_valid), 32'd0);
    chk("release_idle_ready", 32'(start_ready), 32'd1);
    chk("release_no_accept", 32'(busy), 32'd0);
    start_valid = 1'b0;
  endtask

  // One WIDTH=1 transaction.
  task automatic do_add1(input logic a_i, input logic b_i, input logic c_i);
    logic [1:0] exp;
    int         lat;
    exp = 2'(a_i) + 2'(b_i) + 2'(c_i);
    s1_a = a_i; s1_b = b_i; s1_cin = c_i; s1_start_valid = 1'b1;
    @(posedge clk); #1;
    s1_start_valid = 1'b0;
    lat = 0;
    while (!s1_done_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency1", 32'(lat), 32'd1);
    chk("sum1", 32'(s1_sum), 32'(exp[0]));
    chk("cout1", 32'(s1_cout), 32'(exp[1]));
    s1_done_ready = 1'b1;
    @(posedge clk); #1;
    s1_done_ready = 1'b0;
    chk("release1", 32'(s1_done_valid), 32'd0);
  endtask

  initial begin
    n_vec = 0; n_mis = 0;
    rst = 1'b1;
    start_valid = 1'b0; a = '0; b = '0; cin = 1'b0; done_ready = 1'b0;
    s1_start_valid = 1'b0; s1_a = '0; s1_b = '0; s1_cin = 1'b0; s1_done_ready = 1'b0;
    #12;
    chk("rst_ready", 32'(start_ready), 32'd1);
    chk("rst_valid", 32'(done_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst1_ready", 32'(s1_start_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed WIDTH=8 cases.
    do_add8(8'd3,   8'd5,   1'b0, 0, 1'b0);
    do_add8(8'd255, 8'd1,   1'b0, 0, 1'b0);
    do_add8(8'd255, 8'd255, 1'b1, 0, 1'b0);
    do_add8(8'd77,  8'd200, 1'b1, 5, 1'b0);
    do_add8(8'd18,  8'd45,  1'b0, 2, 1'b1);
    do_add8(8'd0,   8'd0,   1'b0, 1, 1'b0);

    // Reset while processing bit 3 aborts the add.
    a = 8'd100; b = 8'd77; cin = 1'b1; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ready", 32'(start_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(done_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    do_add8(8'd10, 8'd20, 1'b0, 0, 1'b0);

    // Randomized WIDTH=8 traffic.
    for (int k = 0; k < 30; k++) begin
      do_add8(8'($urandom), 8'($urandom), 1'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom));
    end

    // WIDTH=1: every operand combination.
    for (int k = 0; k < 8; k++) begin
      do_add1(1'(k >> 2), 1'(k >> 1), 1'(k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
